// File: rtl/sub_pkg.sv
// Shared types and elaboration helpers for the digit-serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Legal when the word splits into a whole number of digits of at least one bit.
  function automatic bit cfg_legal(int unsigned width, int unsigned digit);
    return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_sub_if.sv
// Start/done request bus between a requester and serial_sub.
interface serial_sub_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bi;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bo;
  logic             ovf;

  modport master (output start, a, b, bi, input busy, done, d, bo, ovf);
  modport slave  (input start, a, b, bi, output busy, done, d, bo, ovf);
endinterface

// File: rtl/digit_sub.sv
// Combinational DIGIT-bit ripple-borrow subtractor slice.
module digit_sub #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             bin_i,
  output logic [DIGIT-1:0] d_o,
  output logic             bout_o,
  output logic             bmsb_in_o
);

  logic [DIGIT:0] brw;

  always_comb begin
    brw    = '0;
    d_o    = '0;
    brw[0] = bin_i;
    for (int i = 0; i < int'(DIGIT); i++) begin
      d_o[i]     = a_i[i] ^ b_i[i] ^ brw[i];
      brw[i + 1] = (~a_i[i] & (b_i[i] | brw[i])) | (b_i[i] & brw[i]);
    end
  end

  assign bout_o    = brw[DIGIT];
  assign bmsb_in_o = brw[DIGIT-1];

endmodule

// File: rtl/serial_sub.sv
// Digit-serial D = A - B - BI, DIGIT bits per clock, start/done handshake.
module serial_sub
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input logic         clk_i,
  input logic         rst_ni,
  serial_sub_if.slave bus
);

  localparam int unsigned STEPS = WIDTH / DIGIT;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (!cfg_legal(WIDTH, DIGIT)) begin : g_bad_cfg
    $error("serial_sub: illegal WIDTH/DIGIT combination");
  end

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  a_q, b_q, res_q;
  logic [WIDTH-1:0]  res_d;
  logic              brw_q;
  logic [WIDTH-1:0]  d_q;
  logic              bo_q, ovf_q, busy_q, done_q;
  logic              busy_d, done_d;
  logic              load, step, last, fin;
  logic [DIGIT-1:0]  dg_d;
  logic              dg_bout, dg_bmsb;

  assign last = (cnt_q == CW'(STEPS - 1));

  digit_sub #(.DIGIT(DIGIT)) u_digit (
    .a_i       (a_q[DIGIT-1:0]),
    .b_i       (b_q[DIGIT-1:0]),
    .bin_i     (brw_q),
    .d_o       (dg_d),
    .bout_o    (dg_bout),
    .bmsb_in_o (dg_bmsb)
  );

  // New digit enters at the top so the first (least significant) digit ends up at the bottom.
  assign res_d = (res_q >> DIGIT) | (WIDTH'(dg_d) << (WIDTH - DIGIT));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (last)      state_d = ST_DONE;
      ST_DONE: state_d = bus.start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    fin    = 1'b0;
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
    if (state_q == ST_RUN) begin
      step = 1'b1;
      fin  = last;
    end else begin
      load = bus.start;
    end
  end

  // Operand/result shifters and held outputs; results only move at completion.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      brw_q  <= 1'b0;
      cnt_q  <= '0;
      d_q    <= '0;
      bo_q   <= 1'b0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (load) begin
        a_q   <= bus.a;
        b_q   <= bus.b;
        brw_q <= bus.bi;
        cnt_q <= '0;
        res_q <= '0;
      end else if (step) begin
        a_q   <= a_q >> DIGIT;
        b_q   <= b_q >> DIGIT;
        brw_q <= dg_bout;
        cnt_q <= cnt_q + CW'(1);
        res_q <= res_d;
      end
      if (fin) begin
        d_q   <= res_d;
        bo_q  <= dg_bout;
        ovf_q <= dg_bout ^ dg_bmsb;
      end
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.d    = d_q;
  assign bus.bo   = bo_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub over several WIDTH/DIGIT configurations.
module tb_serial_sub;

  localparam int NCFG = 5;

  function automatic int unsigned cfg_w(int g);
    return (g == 1) ? 8 : 16;
  endfunction

  function automatic int unsigned cfg_dg(int g);
    case (g)
      0:       return 4;
      1:       return 8;
      2:       return 1;
      3:       return 2;
      default: return 8;
    endcase
  endfunction

  function automatic int steps_of(int g);
    return int'(cfg_w(g) / cfg_dg(g));
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NCFG-1:0]       start_v;
  logic [NCFG-1:0][15:0] a_v, b_v;
  logic [NCFG-1:0]       bi_v;
  logic [NCFG-1:0]       busy_w, done_w, bo_w, ovf_w;
  logic [NCFG-1:0][15:0] d_w;

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int unsigned W  = cfg_w(g);
    localparam int unsigned DG = cfg_dg(g);
    serial_sub_if #(.WIDTH(W)) bus ();
    assign bus.start = start_v[g];
    assign bus.a     = a_v[g][W-1:0];
    assign bus.b     = b_v[g][W-1:0];
    assign bus.bi    = bi_v[g];
    assign busy_w[g] = bus.busy;
    assign done_w[g] = bus.done;
    assign bo_w[g]   = bus.bo;
    assign ovf_w[g]  = bus.ovf;
    assign d_w[g]    = 16'(bus.d);
    serial_sub #(.WIDTH(W), .DIGIT(DG)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
    );
  end

  typedef struct {
    int          cfg;
    int          cyc;
    int          lat;
    logic [15:0] d;
    logic        bo;
    logic        ovf;
  } exp_t;

  typedef struct {
    int          cfg;
    logic [15:0] a;
    logic [15:0] b;
    logic        bi;
    logic [15:0] d;
    logic        bo;
    logic        ovf;
  } vec_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Independent reference: unsigned and signed integer arithmetic.
  task automatic ref_sub(input int g, input logic [15:0] a, input logic [15:0] b, input logic bi,
                         output logic [15:0] d, output logic bo, output logic ovf);
    int unsigned w  = cfg_w(g);
    int unsigned ua = int'(a);
    int unsigned ub = int'(b);
    int unsigned mask = (32'd1 << w) - 32'd1;
    int sa, sb, r;
    d   = 16'((ua - ub - int'(bi)) & mask);
    bo  = (ua < (ub + int'(bi)));
    sa  = a[w-1] ? int'(ua) - (1 << w) : int'(ua);
    sb  = b[w-1] ? int'(ub) - (1 << w) : int'(ub);
    r   = sa - sb - int'(bi);
    ovf = (r < -(1 << (w - 1))) || (r >= (1 << (w - 1)));
  endtask

  // Advance one edge, sample just after it, and score any DONE pulse.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    for (int g = 0; g < NCFG; g++) begin
      if (done_w[g] === 1'b1) begin
        if (q.size() == 0) begin
          chk("spurious_done", 64'(g), 64'hFF);
        end else begin
          e = q.pop_front();
          chk("done_cfg", 64'(g), 64'(e.cfg));
          chk("done_latency", 64'(cyc - e.cyc), 64'(e.lat));
          chk("d", 64'(d_w[g]), 64'(e.d));
          chk("bo", 64'(bo_w[g]), 64'(e.bo));
          chk("ovf", 64'(ovf_w[g]), 64'(e.ovf));
        end
      end
    end
  endtask

  task automatic issue(input int g, input logic [15:0] a, input logic [15:0] b, input logic bi,
                       input bit push, input logic [15:0] ed, input logic ebo, input logic eovf);
    start_v[g] = 1'b1;
    a_v[g]     = a;
    b_v[g]     = b;
    bi_v[g]    = bi;
    if (push) q.push_back('{cfg: g, cyc: cyc + 1, lat: steps_of(g), d: ed, bo: ebo, ovf: eovf});
    tick();
    start_v[g] = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", 64'(q.size()), 64'd0);
    q.delete();
  endtask

  vec_t vecs[8];

  initial begin
    logic [15:0] rd, ra, rb;
    logic        rbo, rovf, rbi;

    vecs[0] = '{0, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[1] = '{0, 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{0, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[3] = '{0, 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[4] = '{0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{0, 16'h0000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[6] = '{0, 16'hABCD, 16'h1111, 1'b1, 16'h9ABB, 1'b0, 1'b0};
    vecs[7] = '{1, 16'h0010, 16'h0020, 1'b0, 16'h00F0, 1'b1, 1'b0};

    start_v = '0;
    a_v     = '0;
    b_v     = '0;
    bi_v    = '0;

    // Reset, with START asserted during a reset edge
    rst_n = 1'b0;
    tick();
    start_v[0] = 1'b1;
    a_v[0] = 16'h1234;
    tick();
    chk("rst_start_busy", 64'(busy_w[0]), 64'd0);
    start_v[0] = 1'b0;
    tick();
    for (int g = 0; g < NCFG; g++) begin
      chk("rst_busy", 64'(busy_w[g]), 64'd0);
      chk("rst_done", 64'(done_w[g]), 64'd0);
      chk("rst_d", 64'(d_w[g]), 64'd0);
      chk("rst_bo_ovf", 64'({bo_w[g], ovf_w[g]}), 64'd0);
    end
    rst_n = 1'b1;
    tick();

    // Basic transaction with BUSY/DONE timing per edge
    issue(0, 16'h1234, 16'h0234, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0);
    for (int e = 0; e < 4; e++) begin
      chk("basic_busy_run", 64'(busy_w[0]), 64'd1);
      chk("basic_done_early", 64'(done_w[0]), 64'd0);
      tick();
    end
    chk("basic_busy_at_done", 64'(busy_w[0]), 64'd0);
    chk("basic_done_pulse", 64'(done_w[0]), 64'd1);
    tick();
    chk("basic_done_drop", 64'(done_w[0]), 64'd0);
    chk("basic_d_held", 64'(d_w[0]), 64'h1000);
    drain(4);

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].cfg, vecs[i].a, vecs[i].b, vecs[i].bi, 1'b1, vecs[i].d, vecs[i].bo, vecs[i].ovf);
      drain(30);
      tick();
    end

    // START during RUN is ignored
    issue(0, 16'h5555, 16'h1111, 1'b0, 1'b1, 16'h4444, 1'b0, 1'b0);
    tick();
    issue(0, 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    drain(20);
    for (int i = 0; i < 6; i++) tick();
    chk("ignored_busy", 64'(busy_w[0]), 64'd0);

    // Back-to-back: START held high through DONE
    start_v[0] = 1'b1;
    a_v[0] = 16'h9000; b_v[0] = 16'h1000; bi_v[0] = 1'b0;
    q.push_back('{cfg: 0, cyc: cyc + 1, lat: 4, d: 16'h8000, bo: 1'b0, ovf: 1'b0});
    q.push_back('{cfg: 0, cyc: cyc + 6, lat: 4, d: 16'hFEFF, bo: 1'b1, ovf: 1'b0});
    tick();
    a_v[0] = 16'h0100; b_v[0] = 16'h0200; bi_v[0] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    start_v[0] = 1'b0;
    chk("b2b_rerun_busy", 64'(busy_w[0]), 64'd1);
    chk("b2b_rerun_done", 64'(done_w[0]), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_d_hold", 64'(d_w[0]), 64'h8000);
      tick();
    end
    drain(4);
    tick();

    // Reset mid-RUN aborts and clears held results
    issue(0, 16'h7777, 16'h0001, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    chk("abort_busy", 64'(busy_w[0]), 64'd0);
    chk("abort_d", 64'(d_w[0]), 64'd0);
    chk("abort_bo_ovf", 64'({bo_w[0], ovf_w[0]}), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("abort_no_done", 64'(done_w[0]), 64'd0);
    issue(0, 16'h4321, 16'h1234, 1'b0, 1'b1, 16'h30ED, 1'b0, 1'b0);
    drain(8);

    // Random sweep against the reference model on every configuration
    for (int g = 0; g < NCFG; g++) begin
      for (int n = 0; n < 40; n++) begin
        ra  = 16'($urandom_range(0, 65535));
        rb  = 16'($urandom_range(0, 65535));
        rbi = 1'($urandom_range(0, 1));
        if (cfg_w(g) == 8) begin
          ra = ra & 16'h00FF;
          rb = rb & 16'h00FF;
        end
        ref_sub(g, ra, rb, rbi, rd, rbo, rovf);
        issue(g, ra, rb, rbi, 1'b1, rd, rbo, rovf);
        drain(40);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
